message_framer: RTL

- Parametrised successor to the fixed two-section measurement message. Snapshots NUM_FIELDS signed measurement fields plus the 3-bit signal type on out_trig.
- Serialises the snapshot as a byte frame: header, type, length, payload, XOR checksum. Output is a valid/ready byte stream that feeds the UART TX toward the STM32.
- Sits between the demodulation measurement blocks and the UART transmitter.

---
 rtl/message_framer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/message_framer.sv
// Snapshots NUM_FIELDS signed measurement fields plus signal type and streams them as a
// header/type/len/payload/xor-checksum byte frame. Optional build macro: COMPACT_FRAME_EN.
module message_framer #(
  parameter int unsigned DATA_WIDTH  = 14,
  parameter int unsigned NUM_FIELDS  = 6,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             meas_trig,
  input  logic                             out_trig,
  input  logic [2:0]                       signal_type,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] fields_in,
  input  logic [NUM_FIELDS-1:0]            field_mask,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             frame_abort,
  output logic [7:0]                       drop_cnt
);

  localparam int unsigned BPF     = (DATA_WIDTH + 7) / 8;
  localparam int unsigned EXT_W   = BPF * 8;
  localparam int unsigned FLD_W   = NUM_FIELDS * DATA_WIDTH;
  localparam logic [2:0]  TYPE_NA = 3'b100;
  localparam logic [1:0]  BIDX_LAST = 2'(BPF - 1);
`ifdef COMPACT_FRAME_EN
  localparam logic [3:0]  NFLD_CLR = 4'd0;
`else
  localparam logic [3:0]  NFLD_CLR = 4'(NUM_FIELDS);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_TYPE, S_LEN, S_PAYLOAD, S_CKSUM
  } state_e;

  state_e           state_q, state_d;
  logic [FLD_W-1:0] fields_q, fields_d;
  logic [3:0]       nfld_q, nfld_d;
  logic [2:0]       type_q, type_d;
  logic [3:0]       fidx_q, fidx_d;
  logic [1:0]       bidx_q, bidx_d;
  logic [7:0]       cksum_q, cksum_d;
  logic             abort_q, abort_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             abrt_q, abrt_d;
  logic [7:0]       drop_q, drop_d;

  logic [FLD_W-1:0] pack_fields;
  logic [3:0]       pack_n;
  logic [7:0]       len_byte;
  logic [7:0]       pay_byte;
  logic             xfer;

  // Sign-extend field fi of the snapshot to BPF bytes and return byte bi, MSB byte first.
  function automatic logic [7:0] pick_byte(input logic [FLD_W-1:0] f,
                                           input logic [3:0] fi, input logic [1:0] bi);
    logic [DATA_WIDTH-1:0] raw;
    logic [EXT_W-1:0]      ext;
    raw = f[int'(fi)*DATA_WIDTH +: DATA_WIDTH];
    ext = EXT_W'($signed(raw));
    return ext[(BPF - 1 - int'(bi))*8 +: 8];
  endfunction

  // Snapshot is stored pre-masked (and packed in compact mode) so the payload walk needs no mask.
  always_comb begin
    pack_fields = '0;
    pack_n      = '0;
`ifdef COMPACT_FRAME_EN
    for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
      if (field_mask[k]) begin
        pack_fields[int'(pack_n)*DATA_WIDTH +: DATA_WIDTH] = fields_in[k*DATA_WIDTH +: DATA_WIDTH];
        pack_n = pack_n + 4'd1;
      end
    end
`else
    for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
      if (field_mask[k]) begin
        pack_fields[k*DATA_WIDTH +: DATA_WIDTH] = fields_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    pack_n = 4'(NUM_FIELDS);
`endif
  end

  assign len_byte = 8'(32'(nfld_q) * BPF);
  assign xfer     = tx_valid_q && tx_ready;

  always_comb begin
    state_d    = state_q;
    fields_d   = fields_q;
    nfld_d     = nfld_q;
    type_d     = type_q;
    fidx_d     = fidx_q;
    bidx_d     = bidx_q;
    cksum_d    = cksum_q;
    abort_d    = abort_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    abrt_d     = 1'b0;
    drop_d     = drop_q;
    pay_byte   = 8'h00;

    if (state_q == S_IDLE) begin
      if (meas_trig) begin
        fields_d = '0;
        nfld_d   = NFLD_CLR;
        type_d   = TYPE_NA;
      end else if (out_trig) begin
        fields_d   = pack_fields;
        nfld_d     = pack_n;
        type_d     = signal_type;
        fidx_d     = 4'd0;
        bidx_d     = 2'd0;
        cksum_d    = 8'h00;
        tx_data_d  = HEADER_BYTE;
        tx_valid_d = 1'b1;
        state_d    = S_HDR;
      end
    end else begin
      if (out_trig && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      if (meas_trig) abort_d = 1'b1;
      if (xfer) begin
        if (abort_q || meas_trig) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
          abrt_d     = 1'b1;
          abort_d    = 1'b0;
          fidx_d     = 4'd0;
          bidx_d     = 2'd0;
          fields_d   = '0;
          nfld_d     = NFLD_CLR;
          type_d     = TYPE_NA;
        end else begin
          case (state_q)
            S_HDR: begin
              state_d   = S_TYPE;
              tx_data_d = {5'b0, type_q};
              cksum_d   = {5'b0, type_q};
            end
            S_TYPE: begin
              state_d   = S_LEN;
              tx_data_d = len_byte;
              cksum_d   = cksum_q ^ len_byte;
            end
            S_LEN: begin
              if (nfld_q == 4'd0) begin
                state_d   = S_CKSUM;
                tx_data_d = cksum_q;
              end else begin
                state_d   = S_PAYLOAD;
                pay_byte  = pick_byte(fields_q, 4'd0, 2'd0);
                tx_data_d = pay_byte;
                cksum_d   = cksum_q ^ pay_byte;
              end
            end
            S_PAYLOAD: begin
              if (bidx_q == BIDX_LAST && fidx_q == nfld_q - 4'd1) begin
                fidx_d    = 4'd0;
                bidx_d    = 2'd0;
                state_d   = S_CKSUM;
                tx_data_d = cksum_q;
              end else begin
                if (bidx_q == BIDX_LAST) begin
                  fidx_d = fidx_q + 4'd1;
                  bidx_d = 2'd0;
                end else begin
                  bidx_d = bidx_q + 2'd1;
                end
                pay_byte  = pick_byte(fields_q, fidx_d, bidx_d);
                tx_data_d = pay_byte;
                cksum_d   = cksum_q ^ pay_byte;
              end
            end
            S_CKSUM: begin
              state_d    = S_IDLE;
              tx_valid_d = 1'b0;
              done_d     = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fields_q   <= '0;
      nfld_q     <= NFLD_CLR;
      type_q     <= TYPE_NA;
      fidx_q     <= 4'd0;
      bidx_q     <= 2'd0;
      cksum_q    <= 8'h00;
      abort_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abrt_q     <= 1'b0;
      drop_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      fields_q   <= fields_d;
      nfld_q     <= nfld_d;
      type_q     <= type_d;
      fidx_q     <= fidx_d;
      bidx_q     <= bidx_d;
      cksum_q    <= cksum_d;
      abort_q    <= abort_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= done_d;
      abrt_q     <= abrt_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_abort = abrt_q;
  assign drop_cnt    = drop_q;

endmodule
